cpu_host_loader: RTL and testbench



---
 rtl/cpu_host_loader_pkg.sv | 21 ++
 rtl/run_budget_counter.sv | 39 +++
 rtl/cpu_host_loader.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_host_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_host_loader_pkg.sv
// Shared opcodes, FSM state encoding and default counter width for the host loader.
package cpu_host_loader_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  localparam logic [2:0] OP_WR_IMEM = 3'd1;
  localparam logic [2:0] OP_WR_DMEM = 3'd2;
  localparam logic [2:0] OP_RD_IMEM = 3'd3;
  localparam logic [2:0] OP_RD_DMEM = 3'd4;
  localparam logic [2:0] OP_RUN     = 3'd5;
  localparam logic [2:0] OP_HALT    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/run_budget_counter.sv
// Cycle counter for a CPU run: loads a budget, counts enabled cycles, saturates, flags expiry.
module run_budget_counter
  import cpu_host_loader_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] budget,
  input  logic             run,
  output logic             expired,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] budget_q;
  logic [CNT_W-1:0] count_inc;

  // count includes the current cycle while running, so the completing edge sees the final total
  always_comb begin
    count_inc = (&count_q) ? count_q : count_q + 1'b1;
    count     = run ? count_inc : count_q;
    expired   = run && (|budget_q) && (count_inc == budget_q);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q  <= '0;
      budget_q <= '0;
    end else if (load) begin
      count_q  <= '0;
      budget_q <= budget;
    end else if (run) begin
      count_q  <= count_inc;
    end
  end

endmodule

// File: rtl/cpu_host_loader.sv
// Host-side command initiator: memory port writes/reads and budgeted CPU run gating.
module cpu_host_loader
  import cpu_host_loader_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);

  state_t state, state_n;

  logic        rdy_q;
  logic [63:0] addr_q;
  logic [63:0] data_q;
  logic        dmem_q;
  logic        done_pend;
  logic [63:0] done_cnt;

  logic        cmd_fire;
  logic        rsp_free;
  logic        rsp_load;
  logic [63:0] rsp_data_n;
  logic        rsp_err_n;
  logic        pend_set;
  logic        pend_clr;
  logic        lat_cmd;
  logic        lat_dmem;
  logic        ctr_load;
  logic        ctr_expired;
  logic [CNT_W-1:0] ctr_count;
  logic        run_end;
  logic        halt_fire;
  logic        err_fire;

  run_budget_counter #(.CNT_W(CNT_W)) u_run_budget_counter (
    .clk     (clk),
    .arst_n  (arst_n),
    .load    (ctr_load),
    .budget  (cmd_data[CNT_W-1:0]),
    .run     (enable),
    .expired (ctr_expired),
    .count   (ctr_count)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    rsp_load    = 1'b0;
    rsp_data_n  = '0;
    rsp_err_n   = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    lat_cmd     = 1'b0;
    lat_dmem    = 1'b0;
    ctr_load    = 1'b0;
    halt_fire   = 1'b0;
    err_fire    = 1'b0;
    run_end     = 1'b0;

    cmd_ready   = rdy_q && !rsp_valid && (state == ST_IDLE || state == ST_RUN);
    cmd_fire    = cmd_valid && cmd_ready;
    rsp_free    = !rsp_valid || rsp_ready;
    enable      = (state == ST_RUN);

    wen_ext     = (state == ST_WRITE)  && !dmem_q;
    ren_ext     = (state == ST_RD_REQ) && !dmem_q;
    wen_ext_2   = (state == ST_WRITE)  &&  dmem_q;
    ren_ext_2   = (state == ST_RD_REQ) &&  dmem_q;
    addr_ext    = (wen_ext   || ren_ext)   ? addr_q : '0;
    addr_ext_2  = (wen_ext_2 || ren_ext_2) ? addr_q : '0;
    wdata_ext   = wen_ext   ? data_q[31:0] : '0;
    wdata_ext_2 = wen_ext_2 ? data_q       : '0;

    case (state)
      ST_IDLE: begin
        if (done_pend && rsp_ready) begin
          rsp_load   = 1'b1;
          rsp_data_n = done_cnt;
          pend_clr   = 1'b1;
        end else if (cmd_fire) begin
          case (cmd_op)
            OP_WR_IMEM, OP_WR_DMEM: begin
              state_n  = ST_WRITE;
              lat_cmd  = 1'b1;
              lat_dmem = (cmd_op == OP_WR_DMEM);
            end
            OP_RD_IMEM, OP_RD_DMEM: begin
              state_n  = ST_RD_REQ;
              lat_cmd  = 1'b1;
              lat_dmem = (cmd_op == OP_RD_DMEM);
            end
            OP_RUN: begin
              state_n  = ST_RUN;
              ctr_load = 1'b1;
            end
            OP_HALT: begin
              rsp_load = 1'b1;
            end
            default: begin
              rsp_load  = 1'b1;
              rsp_err_n = 1'b1;
            end
          endcase
        end
      end
      ST_WRITE: begin
        state_n  = ST_IDLE;
        rsp_load = 1'b1;
      end
      ST_RD_REQ: begin
        state_n = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_n    = ST_IDLE;
        rsp_load   = 1'b1;
        rsp_data_n = dmem_q ? rdata_ext_2 : {32'h0, rdata_ext};
      end
      ST_RUN: begin
        halt_fire = cmd_fire && (cmd_op == OP_HALT);
        err_fire  = cmd_fire && (cmd_op != OP_HALT);
        run_end   = ctr_expired || halt_fire;
        if (err_fire) begin
          rsp_load  = 1'b1;
          rsp_err_n = 1'b1;
        end
        // a completion that cannot take the response slot now is parked until the slot drains
        if (run_end) begin
          state_n = ST_IDLE;
          if (err_fire || !rsp_free) begin
            pend_set = 1'b1;
          end else begin
            rsp_load   = 1'b1;
            rsp_data_n = 64'(ctr_count);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      dmem_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      done_pend <= 1'b0;
      done_cnt  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (lat_cmd) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        dmem_q <= lat_dmem;
      end
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rsp_data_n;
        rsp_err   <= rsp_err_n;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_data  <= '0;
        rsp_err   <= 1'b0;
      end
      if (pend_set) begin
        done_pend <= 1'b1;
        done_cnt  <= 64'(ctr_count);
      end else if (pend_clr) begin
        done_pend <= 1'b0;
        done_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_host_loader.sv
// Self-checking bench for cpu_host_loader: vector table plus multi-cycle run/reset sequences.
module tb_cpu_host_loader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [63:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext = '0;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;

  cpu_host_loader #(.CNT_W(32)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .enable      (enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  always #5 clk = ~clk;

  // memory model: read data appears in the cycle after ren
  logic [31:0] imem [logic [63:0]];
  logic [63:0] dmem [logic [63:0]];
  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext]   = wdata_ext;
    if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
    if (ren_ext)   rdata_ext   <= imem.exists(addr_ext)   ? imem[addr_ext]   : 32'hBAD0_0001;
    if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 64'hBAD0_0000_0000_0002;
  end

  int wen_i_cnt = 0, wen_d_cnt = 0, ren_i_cnt = 0, ren_d_cnt = 0, en_cnt = 0, viol_cnt = 0;
  logic [63:0] last_i_addr = '0, last_d_addr = '0, last_d_wdata = '0;
  logic [31:0] last_i_wdata = '0;
  always @(negedge clk) begin
    if (wen_ext)   begin wen_i_cnt++; last_i_addr = addr_ext; last_i_wdata = wdata_ext; end
    if (wen_ext_2) begin wen_d_cnt++; last_d_addr = addr_ext_2; last_d_wdata = wdata_ext_2; end
    if (ren_ext)   ren_i_cnt++;
    if (ren_ext_2) ren_d_cnt++;
    if (enable)    en_cnt++;
    if ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) viol_cnt++;
    if (!(wen_ext || ren_ext) && (|addr_ext)) viol_cnt++;
    if (!(wen_ext_2 || ren_ext_2) && (|addr_ext_2)) viol_cnt++;
    if (!wen_ext && (|wdata_ext)) viol_cnt++;
    if (!wen_ext_2 && (|wdata_ext_2)) viol_cnt++;
  end

  logic [12:0] out_bits;
  assign out_bits = {cmd_ready, rsp_valid, rsp_err, enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2,
                     |rsp_data, |addr_ext, |wdata_ext, |addr_ext_2, |wdata_ext_2};

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total_cnt++;
      $display("FAIL cmd_accept_timeout: op %0d not accepted within 100 cycles", op);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    end
  endtask

  task automatic get_rsp(output logic [63:0] d, output logic e, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
    if (!rsp_valid) begin
      total_cnt++;
      $display("FAIL rsp_timeout: no response within 200 cycles");
      d = '1; e = 1'b1;
    end else begin
      d = rsp_data; e = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic        exp_err;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [63:0] d, d0;
    logic        e;
    int          lat, en0, wi0, wd0, ri0, rd0, stable;

    vecs[0]  = '{3'd1, 64'h8,  64'h0000_0000_00A0_0093, 1'b0, 64'h0, 2};
    vecs[1]  = '{3'd2, 64'h10, 64'hDEAD_BEEF_0123_4567, 1'b0, 64'h0, 2};
    vecs[2]  = '{3'd4, 64'h10, 64'h0,                   1'b0, 64'hDEAD_BEEF_0123_4567, 3};
    vecs[3]  = '{3'd3, 64'h8,  64'h0,                   1'b0, 64'h0000_0000_00A0_0093, 3};
    vecs[4]  = '{3'd6, 64'h0,  64'h0,                   1'b0, 64'h0, 1};
    vecs[5]  = '{3'd0, 64'h40, 64'h1234,                1'b1, 64'h0, 1};
    vecs[6]  = '{3'd7, 64'h40, 64'h1234,                1'b1, 64'h0, 1};
    vecs[7]  = '{3'd1, 64'h20, 64'hFFFF_FFFF_1234_5678, 1'b0, 64'h0, 2};
    vecs[8]  = '{3'd3, 64'h20, 64'h0,                   1'b0, 64'h0000_0000_1234_5678, 3};
    vecs[9]  = '{3'd2, 64'h18, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 2};
    vecs[10] = '{3'd4, 64'h18, 64'h0,                   1'b0, 64'h0123_4567_89AB_CDEF, 3};

    #3;
    chk("reset_outputs", 64'(out_bits), 64'h0);
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'h1);

    for (int unsigned i = 0; i < 11; i++) begin
      wi0 = wen_i_cnt; wd0 = wen_d_cnt; ri0 = ren_i_cnt; rd0 = ren_d_cnt;
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      get_rsp(d, e, lat);
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_wen_imem", i), 64'(wen_i_cnt - wi0), 64'(vecs[i].op == 3'd1));
      chk($sformatf("v%0d_wen_dmem", i), 64'(wen_d_cnt - wd0), 64'(vecs[i].op == 3'd2));
      chk($sformatf("v%0d_ren_imem", i), 64'(ren_i_cnt - ri0), 64'(vecs[i].op == 3'd3));
      chk($sformatf("v%0d_ren_dmem", i), 64'(ren_d_cnt - rd0), 64'(vecs[i].op == 3'd4));
      if (vecs[i].op == 3'd1) begin
        chk($sformatf("v%0d_imem_addr", i), last_i_addr, vecs[i].addr);
        chk($sformatf("v%0d_imem_wdata", i), 64'(last_i_wdata), {32'h0, vecs[i].data[31:0]});
      end
      if (vecs[i].op == 3'd2) begin
        chk($sformatf("v%0d_dmem_addr", i), last_d_addr, vecs[i].addr);
        chk($sformatf("v%0d_dmem_wdata", i), last_d_wdata, vecs[i].data);
      end
    end

    // RUN B=5, response taken immediately
    en0 = en_cnt;
    send(3'd5, 64'h0, 64'd5);
    get_rsp(d, e, lat);
    chk("run5_data", d, 64'd5);
    chk("run5_err", 64'(e), 64'h0);
    chk("run5_latency", 64'(lat), 64'd6);
    chk("run5_enable_cycles", 64'(en_cnt - en0), 64'd5);

    // RUN B=5, response held for 4 cycles
    en0 = en_cnt;
    send(3'd5, 64'h0, 64'd5);
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    d0 = rsp_data;
    chk("run5h_first_data", d0, 64'd5);
    stable = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_data == d0 && !rsp_err && !cmd_ready) stable++;
    end
    chk("run5h_held_stable", 64'(stable), 64'd4);
    get_rsp(d, e, lat);
    chk("run5h_data", d, 64'd5);
    chk("run5h_enable_cycles", 64'(en_cnt - en0), 64'd5);

    // unbounded RUN, HALT accepted after 12 enabled cycles
    en0 = en_cnt;
    send(3'd5, 64'h0, 64'd0);
    repeat (12) @(negedge clk);
    send(3'd6, 64'h0, 64'h0);
    @(negedge clk);
    chk("halt_enable_low", 64'(enable), 64'h0);
    chk("halt_rsp_valid", 64'(rsp_valid), 64'h1);
    get_rsp(d, e, lat);
    chk("halt_data", d, 64'd12);
    chk("halt_err", 64'(e), 64'h0);
    repeat (3) @(negedge clk);
    chk("halt_single_rsp", 64'(rsp_valid), 64'h0);
    chk("halt_enable_cycles", 64'(en_cnt - en0), 64'd12);

    // errors during RUN B=20
    en0 = en_cnt; wi0 = wen_i_cnt;
    send(3'd5, 64'h0, 64'd20);
    send(3'd1, 64'h100, 64'h5555);
    get_rsp(d, e, lat);
    chk("run20_wr_err", 64'(e), 64'h1);
    chk("run20_wr_data", d, 64'h0);
    chk("run20_wr_latency", 64'(lat), 64'd1);
    send(3'd7, 64'h0, 64'h0);
    get_rsp(d, e, lat);
    chk("run20_op7_err", 64'(e), 64'h1);
    chk("run20_op7_data", d, 64'h0);
    get_rsp(d, e, lat);
    chk("run20_done_data", d, 64'd20);
    chk("run20_done_err", 64'(e), 64'h0);
    chk("run20_no_wen", 64'(wen_i_cnt - wi0), 64'h0);
    chk("run20_enable_cycles", 64'(en_cnt - en0), 64'd20);

    // run expires while an error response is still pending
    en0 = en_cnt; wd0 = wen_d_cnt;
    send(3'd5, 64'h0, 64'd3);
    send(3'd2, 64'h200, 64'h7777);
    repeat (4) @(negedge clk);
    chk("pend_enable_low", 64'(enable), 64'h0);
    chk("pend_err_held", 64'({rsp_valid, rsp_err}), 64'h3);
    get_rsp(d, e, lat);
    chk("pend_first_err", 64'(e), 64'h1);
    get_rsp(d, e, lat);
    chk("pend_done_data", d, 64'd3);
    chk("pend_done_err", 64'(e), 64'h0);
    chk("pend_done_latency", 64'(lat), 64'd1);
    chk("pend_enable_cycles", 64'(en_cnt - en0), 64'd3);
    chk("pend_no_wen", 64'(wen_d_cnt - wd0), 64'h0);

    // budget expiry and HALT on the same edge
    en0 = en_cnt;
    send(3'd5, 64'h0, 64'd4);
    repeat (4) @(negedge clk);
    send(3'd6, 64'h0, 64'h0);
    get_rsp(d, e, lat);
    chk("same_edge_data", d, 64'd4);
    repeat (3) @(negedge clk);
    chk("same_edge_single_rsp", 64'(rsp_valid), 64'h0);
    chk("same_edge_enable_cycles", 64'(en_cnt - en0), 64'd4);

    // reset while waiting for read data
    send(3'd3, 64'h8, 64'h0);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'(out_bits), 64'h0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("midreset_ready", 64'(cmd_ready), 64'h1);
    chk("midreset_no_rsp", 64'(rsp_valid), 64'h0);
    send(3'd3, 64'h8, 64'h0);
    get_rsp(d, e, lat);
    chk("midreset_rd_data", d, 64'h0000_0000_00A0_0093);
    chk("midreset_rd_latency", 64'(lat), 64'd3);

    chk("port_rules", 64'(viol_cnt), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
